imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter TAGW, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have parameter CNTW, default 8, width of the illegal-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 cnt_clr  input  1  synchronous clear of illegal_cnt.
REQ-008 in_valid  input  1  in_instr/in_tag valid.
REQ-009 in_ready  output  1  block can accept; driven from a register.
REQ-010 in_instr  input  32  raw RV32/RV64 instruction word.
REQ-011 in_tag  input  TAGW  opaque sideband, returned unchanged.
REQ-012 out_valid  output  1  out_* valid.
REQ-013 out_ready  input  1  consumer accepts.
REQ-014 out_imm  output  XLEN  extended immediate.
REQ-015 out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
REQ-016 out_tag  output  TAGW  tag of the entry.
REQ-017 out_illegal  output  1  opcode has no immediate format.
REQ-018 illegal_cnt  output  CNTW  saturating count of accepted illegal instructions.

Function
REQ-019 Decode SHALL use opcode in_instr[6:0]: 0000011, 0010011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0011011 -> I only when XLEN=64.
REQ-020 Opcode 0010011 (or 0011011) with funct3 001/101 SHALL be SHAMT: zero-extended in_instr[24:20] (XLEN=32, or opcode 0011011) or in_instr[25:20] (XLEN=64, opcode 0010011).
REQ-021 I/S/B/J immediates SHALL be sign-extended from in_instr[31] to XLEN; B and J bit 0 SHALL be 0; U SHALL be {in_instr[31:12], 12'b0} sign-extended to XLEN.
REQ-022 Any other opcode SHALL give out_fmt=0, out_imm=0, out_illegal=1.
REQ-023 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-024 Storage SHALL be a 2-entry skid buffer (output register plus skid register); entries leave in acceptance order.
REQ-025 Latency SHALL be 1 cycle: an instruction accepted at edge N appears on out_* after edge N when the output register is empty or draining.
REQ-026 in_ready SHALL be 1 exactly when the skid register is empty; full throughput (1/cycle) SHALL be sustained while out_ready=1.
REQ-027 With out_ready=0, out_* SHALL hold stable; at most 2 entries are held, then in_ready=0.
REQ-028 flush SHALL empty both entries at the edge; an input transferred in the same cycle SHALL be discarded and not counted.
REQ-029 illegal_cnt SHALL increment on each non-flushed acceptance with illegal decode; saturate at all-ones.
REQ-030 cnt_clr with a simultaneous counted illegal acceptance SHALL result in illegal_cnt=1; cnt_clr alone gives 0.
REQ-031 Flush SHALL NOT alter illegal_cnt.

Reset
REQ-032 While rst_n=0: out_valid=0, in_ready=0, out_imm=0, out_fmt=0, out_tag=0, out_illegal=0, illegal_cnt=0, both entries empty.
REQ-033 in_ready SHALL rise at the first rising clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-stream SHALL drop all buffered entries immediately, without waiting for clk.

Verification
REQ-035 XLEN=32, in_instr=0xFF813083 (ld x1,-8(x2)), out_ready=1 -> next cycle out_imm=0xFFFFFFF8, out_fmt=1; XLEN=64 -> 0xFFFFFFFFFFFFFFF8.
REQ-036 in_instr=0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, fmt=3; 0x123452B7 (lui) -> 0x12345000, fmt=4; 0x00309093 (slli x1,x1,3) -> 3, fmt=6.
REQ-037 out_ready=0, offer tags 1,2,3 back-to-back -> tags 1,2 accepted, in_ready=0 on 3rd; raise out_ready -> tags 1,2,3 emerge in order, no loss/duplication.
REQ-038 Feed 0x0000007F 300 times with CNTW=8 -> out_illegal=1, out_imm=0 each time, illegal_cnt saturates at 0xFF; cnt_clr with one more illegal -> 1.
REQ-039 Two entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
REQ-040 Drop rst_n mid-cycle with entries held -> out_valid=0, in_ready=0 immediately; after release in_ready=1 at first edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer.
// Decodes each accepted instruction word into its extended immediate plus format code.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            cnt_clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal,
  output logic [CNTW-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FmtNone  = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtShamt = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [TAGW-1:0] tag;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpImm32  = 7'b0011011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        shift_f3;
  logic        sign;
  fmt_e        dec_fmt;
  logic [63:0] dec_imm64;
  entry_t      dec_entry;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign sign     = in_instr[31];

  always_comb begin
    dec_fmt = FmtNone;
    case (opcode)
      OpLoad, OpJalr, OpSystem: dec_fmt = FmtI;
      OpImm:                    dec_fmt = shift_f3 ? FmtShamt : FmtI;
      OpImm32: begin
        // Word-sized ALU ops only exist on RV64.
        if (XLEN == 64) dec_fmt = shift_f3 ? FmtShamt : FmtI;
      end
      OpStore:                  dec_fmt = FmtS;
      OpBranch:                 dec_fmt = FmtB;
      OpLui, OpAuipc:           dec_fmt = FmtU;
      OpJal:                    dec_fmt = FmtJ;
      default:                  dec_fmt = FmtNone;
    endcase
  end

  // Built at 64 bits then truncated so one expression serves both XLEN settings.
  always_comb begin
    dec_imm64 = '0;
    case (dec_fmt)
      FmtI: dec_imm64 = {{52{sign}}, in_instr[31:20]};
      FmtS: dec_imm64 = {{52{sign}}, in_instr[31:25], in_instr[11:7]};
      FmtB: dec_imm64 = {{52{sign}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FmtU: dec_imm64 = {{32{sign}}, in_instr[31:12], 12'b0};
      FmtJ: dec_imm64 = {{44{sign}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      FmtShamt: begin
        if ((XLEN == 64) && (opcode == OpImm)) dec_imm64 = {58'b0, in_instr[25:20]};
        else                                   dec_imm64 = {59'b0, in_instr[24:20]};
      end
      default: dec_imm64 = '0;
    endcase
  end

  logic unused_imm_hi;
  assign unused_imm_hi = ^dec_imm64;

  always_comb begin
    dec_entry         = '0;
    dec_entry.imm     = dec_imm64[XLEN-1:0];
    dec_entry.fmt     = dec_fmt;
    dec_entry.tag     = in_tag;
    dec_entry.illegal = (dec_fmt == FmtNone);
  end

  // Skid buffer: out_q feeds the consumer, skid_q catches the one beat in flight on a stall.
  entry_t          out_q, out_d, skid_q, skid_d;
  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            accept, pop, cnt_inc;

  assign accept  = in_valid && in_ready_q;
  assign pop     = out_valid_q && out_ready;
  assign cnt_inc = accept && dec_entry.illegal && !flush;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = cnt_inc ? CNTW'(1) : '0;
    end else if (cnt_inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and a scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, cnt_clr, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [4:0]  out_tag;
  logic [7:0]  illegal_cnt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [4:0]  out_tag64;
  logic [7:0]  illegal_cnt64;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;
    logic        ill32, ill64;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAGW(5), .CNTW(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_tag(out_tag), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAGW(5), .CNTW(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_tag(out_tag64), .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
  );

  // Reference decode, written from the ISA immediate layouts.
  function automatic void model(input logic [31:0] i, input bit is64,
                                output logic [63:0] imm, output logic [2:0] fmt);
    logic [6:0] op;
    bit sh;
    op  = i[6:0];
    sh  = (i[14:12] == 3'b001) || (i[14:12] == 3'b101);
    imm = '0;
    fmt = 3'd0;
    if (op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h13 || (op == 7'h1B && is64)) begin
      if ((op == 7'h13 || op == 7'h1B) && sh) begin
        fmt = 3'd6;
        imm = (is64 && op == 7'h13) ? 64'(i[25:20]) : 64'(i[24:20]);
      end else begin
        fmt = 3'd1;
        imm = 64'($signed(i[31:20]));
      end
    end else if (op == 7'h23) begin
      fmt = 3'd2;
      imm = 64'($signed({i[31:25], i[11:7]}));
    end else if (op == 7'h63) begin
      fmt = 3'd3;
      imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    end else if (op == 7'h37 || op == 7'h17) begin
      fmt = 3'd4;
      imm = 64'($signed({i[31:12], 12'h000}));
    end else if (op == 7'h6F) begin
      fmt = 3'd5;
      imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    end
  endfunction

  function automatic exp_t mk(input logic [31:0] i, input logic [4:0] tag);
    exp_t e;
    logic [63:0] m;
    model(i, 1'b0, m, e.fmt32);
    e.imm32 = m[31:0];
    model(i, 1'b1, e.imm64, e.fmt64);
    e.ill32 = (e.fmt32 == 3'd0);
    e.ill64 = (e.fmt64 == 3'd0);
    e.tag   = tag;
    return e;
  endfunction

  // One clock: scoreboard pops on output handshakes and pushes on acceptances at negedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      n_vec++;
      if (out_valid64 !== out_valid || in_ready64 !== in_ready) begin
        n_err++;
        $display("FAIL lockstep: v32=%b v64=%b r32=%b r64=%b", out_valid, out_valid64,
                 in_ready, in_ready64);
      end
      if (out_valid && out_ready && !flush) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got tag=%0d, expected no output", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_imm !== e.imm32 || out_fmt !== e.fmt32 || out_illegal !== e.ill32 ||
              out_tag !== e.tag || out_imm64 !== e.imm64 || out_fmt64 !== e.fmt64 ||
              out_illegal64 !== e.ill64 || out_tag64 !== e.tag) begin
            n_err++;
            $display("FAIL sb_entry: got imm32=%h fmt=%0d ill=%b tag=%0d imm64=%h fmt64=%0d ill64=%b, expected imm32=%h fmt=%0d ill=%b tag=%0d imm64=%h fmt64=%0d ill64=%b",
                     out_imm, out_fmt, out_illegal, out_tag, out_imm64, out_fmt64,
                     out_illegal64, e.imm32, e.fmt32, e.ill32, e.tag, e.imm64, e.fmt64,
                     e.ill64);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(mk(in_instr, in_tag));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== '0 || out_fmt !== '0 ||
        out_tag !== '0 || out_illegal !== 1'b0 || illegal_cnt !== '0 ||
        out_valid64 !== 1'b0 || out_imm64 !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b rdy=%b imm=%h fmt=%0d tag=%0d ill=%b cnt=%0d, expected all 0",
               out_valid, in_ready, out_imm, out_fmt, out_tag, out_illegal, illegal_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rdy_before_edge: got %b, expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rdy_first_edge: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vi  [7] = '{32'hFF813083, 32'hFE000EE3, 32'h123452B7, 32'h00309093,
                             32'h0000007F, 32'h0240009B, 32'h02009093};
    logic [31:0] e32 [7] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000, 32'd3, 32'd0, 32'd0,
                             32'd0};
    logic [63:0] e64 [7] = '{64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, 64'h12345000, 64'd3,
                             64'd0, 64'd36, 64'd32};
    logic [2:0]  f32 [7] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd0, 3'd6};
    logic [2:0]  f64 [7] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd1, 3'd6};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_instr = vi[k];
      in_tag   = 5'(k);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_imm !== e32[k] || out_fmt !== f32[k] ||
          out_imm64 !== e64[k] || out_fmt64 !== f64[k] ||
          out_illegal !== (f32[k] == 3'd0) || out_illegal64 !== (f64[k] == 3'd0)) begin
        n_err++;
        $display("FAIL vector_%0d: got v=%b imm32=%h fmt=%0d imm64=%h fmt64=%0d, expected v=1 imm32=%h fmt=%0d imm64=%h fmt64=%0d",
                 k, out_valid, out_imm, out_fmt, out_imm64, out_fmt64, e32[k], f32[k],
                 e64[k], f64[k]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] got[$];
    bit acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 5'd1;
    tick();
    in_tag = 5'd2;
    tick();
    in_tag = 5'd3;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full: got in_ready=%b, expected 0", in_ready);
    end
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_tag !== 5'd1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_hold: got v=%b tag=%0d rdy=%b, expected v=1 tag=1 rdy=0",
               out_valid, out_tag, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      if (out_valid && out_ready) got.push_back(out_tag);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_vec++;
    if (got.size() != 3 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3) begin
      n_err++;
      $display("FAIL b2b_order: got %0d tags %p, expected 1,2,3", got.size(), got);
    end
    tick();
  endtask

  task automatic test_illegal_sat();
    int exp_cnt;
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_vec++;
    if (illegal_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL cnt_clr_alone: got %0d, expected 0", illegal_cnt);
    end
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    for (int i = 0; i < 300; i++) begin
      in_tag = 5'(i);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL sat_throughput_%0d: got in_ready=%b, expected 1", i, in_ready);
      end
      tick();
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_vec++;
      if (illegal_cnt !== 8'(exp_cnt) || out_illegal !== 1'b1 || out_imm !== '0) begin
        n_err++;
        $display("FAIL sat_cnt_%0d: got cnt=%0d ill=%b imm=%h, expected cnt=%0d ill=1 imm=0",
                 i, illegal_cnt, out_illegal, out_imm, exp_cnt);
      end
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (illegal_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL cnt_clr_with_illegal: got %0d, expected 1", illegal_cnt);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500113;
    in_tag    = 5'd4;
    tick();
    in_tag = 5'd5;
    tick();
    in_instr = 32'h0000007F;
    in_tag   = 5'd6;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL flush_full: got v=%b rdy=%b cnt=%0d, expected v=0 rdy=1 cnt=1",
               out_valid, in_ready, illegal_cnt);
    end
    in_valid = 1'b1;
    in_tag   = 5'd7;
    tick();
    in_tag = 5'd8;
    flush  = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL flush_with_accept: got v=%b rdy=%b cnt=%0d, expected v=0 rdy=1 cnt=2",
               out_valid, in_ready, illegal_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000013;
    in_tag    = 5'd9;
    tick();
    in_tag = 5'd10;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== '0 || illegal_cnt !== '0 ||
        out_valid64 !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b rdy=%b tag=%0d cnt=%0d, expected all 0",
               out_valid, in_ready, out_tag, illegal_cnt);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL async_release_pre: got in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_release_edge: got rdy=%b v=%b, expected rdy=1 v=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h1B, 7'h33, 7'h7F};
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_instr  = {$urandom()} & 32'hFFFF_FF80;
      in_instr[6:0] = ops[$urandom_range(11)];
      in_tag    = 5'($urandom());
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5 && (sb.size() != 0 || out_valid); c++) tick();
    n_vec++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: got %0d pending, out_valid=%b, expected 0 pending",
               sb.size(), out_valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_illegal_sat();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
